// File: rtl/hack_pkg.sv
// Shared definitions for the Hack boot loader and related blocks.
package hack_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    LEN_HI    = 3'd1,
    LEN_LO    = 3'd2,
    DATA_HI   = 3'd3,
    DATA_LO   = 3'd4,
    CHECK     = 3'd5,
    RUN       = 3'd6,
    ERROR     = 3'd7
  } ldr_state_t;

  localparam logic [7:0] LDR_SYNC = 8'hA5;

endpackage

// File: rtl/byte_timer.sv
// Idle counter: counts enabled cycles since the last clear and flags LIMIT-1.
module byte_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  // Next count saturates at LAST; expired is the registered view of count==LAST.
  always_comb begin
    count_d   = count_q;
    expired_d = 1'b0;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + CNT_W'(1);
    end
    expired_d = enable && !clear && (count_d == LAST);
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/rom_loader.sv
// Receives a framed program image over a byte stream, writes it into
// instruction ROM, verifies the checksum and then releases the CPU.
module rom_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              loading,
  output logic              error
);

  localparam int unsigned LEN_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  ldr_state_t        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_wdata_q, rom_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              loading_q, loading_d;
  logic              error_q, error_d;

  logic              timed_c;
  logic              expired_c;
  logic [15:0]       n_words_c;

  // States in which an inter-byte gap is being timed.
  assign timed_c   = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA_HI) || (state_q == DATA_LO) ||
                     (state_q == CHECK);
  assign n_words_c = {len_hi_q, rx_data};

  byte_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid | reload),
    .enable  (timed_c),
    .expired (expired_c)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;

    if (reload) begin
      state_d = WAIT_SYNC;
    end else if (rx_valid) begin
      unique case (state_q)
        WAIT_SYNC, ERROR: begin
          if (rx_data == LDR_SYNC) state_d = LEN_HI;
        end
        LEN_HI: begin
          len_hi_d = rx_data;
          state_d  = LEN_LO;
        end
        LEN_LO: begin
          len_d  = LEN_W'(n_words_c);
          idx_d  = '0;
          csum_d = 8'h00;
          if ((n_words_c == 16'h0000) || (32'(n_words_c) > MAX_WORDS)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA_HI;
          end
        end
        DATA_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          rom_we_d    = 1'b1;
          rom_addr_d  = idx_q;
          rom_wdata_d = {hi_q, rx_data};
          csum_d      = csum_q + rx_data;
          idx_d       = idx_q + ADDR_W'(1);
          if ((LEN_W'(idx_q) + LEN_W'(1)) == len_q) begin
            state_d = CHECK;
          end else begin
            state_d = DATA_HI;
          end
        end
        CHECK: begin
          state_d = (rx_data == csum_q) ? RUN : ERROR;
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_SYNC;
        end
      endcase
    end else if (timed_c && expired_c) begin
      state_d = ERROR;
    end

    cpu_reset_d = (state_d != RUN);
    loading_d   = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                  (state_d == DATA_HI) || (state_d == DATA_LO) ||
                  (state_d == CHECK);
    error_d     = (state_d == ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      len_hi_q    <= 8'h00;
      len_q       <= '0;
      idx_q       <= '0;
      hi_q        <= 8'h00;
      csum_q      <= 8'h00;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= 16'h0000;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      loading_q   <= loading_d;
      error_q     <= error_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign loading   = loading_q;
  assign error     = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with hand-computed expectations.
module tb_rom_loader;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned TMO    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              reload;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_reset;
  logic              loading;
  logic              error;

  int n_chk  = 0;
  int n_pass = 0;

  logic [ADDR_W-1:0] wr_addr [$];
  logic [15:0]       wr_data [$];
  logic [7:0]        fr [$];
  int                base;

  rom_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .reload    (reload),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Log every ROM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (rom_we) begin
      wr_addr.push_back(rom_addr);
      wr_data.push_back(rom_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Reset state.
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_rom_we",    32'(rom_we),    32'd0);
    check("rst_rom_addr",  32'(rom_addr),  32'd0);
    check("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    check("rst_loading",   32'(loading),   32'd0);
    check("rst_error",     32'(error),     32'd0);

    // Noise in WAIT_SYNC is ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(1);
    check("noise_loading", 32'(loading), 32'd0);
    check("noise_error",   32'(error),   32'd0);

    // Good load with one idle cycle between bytes.
    base = wr_addr.size();
    send_byte(8'hA5);
    check("good_loading_rise", 32'(loading), 32'd1);
    idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'h05);
    check("good_we_w0",    32'(rom_we),    32'd1);
    check("good_addr_w0",  32'(rom_addr),  32'd0);
    check("good_wdata_w0", 32'(rom_wdata), 32'h0005);
    idle(1);
    check("good_we_drop",  32'(rom_we),    32'd0);
    send_byte(8'hEC); idle(1);
    send_byte(8'h10); idle(1);
    check("good_cpu_reset_pre", 32'(cpu_reset), 32'd1);
    send_byte(8'h01);
    check("good_cpu_reset_fall", 32'(cpu_reset), 32'd0);
    check("good_error",          32'(error),     32'd0);
    check("good_loading_fall",   32'(loading),   32'd0);
    idle(2);
    check("good_nwrites", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base == 2) begin
      check("good_addr0", 32'(wr_addr[base]),     32'd0);
      check("good_data0", 32'(wr_data[base]),     32'h0005);
      check("good_addr1", 32'(wr_addr[base + 1]), 32'd1);
      check("good_data1", 32'(wr_data[base + 1]), 32'hEC10);
    end

    // RUN ignores bytes, including sync.
    send_byte(8'hA5);
    idle(1);
    check("run_ignore_loading", 32'(loading),   32'd0);
    check("run_ignore_cpu_rst", 32'(cpu_reset), 32'd0);

    // Reload from RUN raises cpu_reset on the next cycle.
    pulse_reload();
    check("run_reload_cpu_reset", 32'(cpu_reset), 32'd1);

    // Bad checksum, then recovery with a good frame from ERROR.
    fr = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h02};
    send_frame(0);
    check("bad_error",     32'(error),     32'd1);
    check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("bad_loading",   32'(loading),   32'd0);
    idle(2);
    base = wr_addr.size();
    send_byte(8'hA5);
    check("rec_error_clear", 32'(error), 32'd0);
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h46};
    send_frame(0);
    check("rec_cpu_reset", 32'(cpu_reset), 32'd0);
    idle(2);
    check("rec_nwrites", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      check("rec_addr", 32'(wr_addr[base]), 32'd0);
      check("rec_data", 32'(wr_data[base]), 32'h1234);
    end
    pulse_reload();

    // Length bounds.
    fr = '{8'hA5, 8'h00, 8'h00};
    send_frame(0);
    check("len_zero_error", 32'(error), 32'd1);
    fr = '{8'hA5, 8'h80, 8'h01};
    send_frame(0);
    check("len_over_error", 32'(error), 32'd1);
    fr = '{8'hA5, 8'h80, 8'h00};
    send_frame(0);
    check("len_max_error",   32'(error),   32'd0);
    check("len_max_loading", 32'(loading), 32'd1);
    pulse_reload();
    check("len_max_reload", 32'(loading), 32'd0);

    // Inter-byte timeout during DATA_LO.
    base = wr_addr.size();
    fr = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_frame(0);
    idle(10);
    check("tmo_early_error",   32'(error),   32'd0);
    check("tmo_early_loading", 32'(loading), 32'd1);
    idle(10);
    check("tmo_error",   32'(error),   32'd1);
    check("tmo_loading", 32'(loading), 32'd0);
    check("tmo_nwrites", 32'(wr_addr.size() - base), 32'd0);

    // Reload coincident with the DATA_LO byte discards it.
    base = wr_addr.size();
    send_frame(0);
    rx_data  = 8'h34;
    rx_valid = 1'b1;
    reload   = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    reload   = 1'b0;
    check("rld_loading",   32'(loading),   32'd0);
    check("rld_error",     32'(error),     32'd0);
    check("rld_cpu_reset", 32'(cpu_reset), 32'd1);
    idle(3);
    check("rld_nwrites", 32'(wr_addr.size() - base), 32'd0);

    // Back-to-back frame of three words; checksum 0xFF.
    base = wr_addr.size();
    fr = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h01, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'hFF};
    send_frame(0);
    check("b2b_cpu_reset", 32'(cpu_reset), 32'd0);
    check("b2b_error",     32'(error),     32'd0);
    idle(2);
    check("b2b_nwrites", 32'(wr_addr.size() - base), 32'd3);
    if (wr_addr.size() - base == 3) begin
      check("b2b_addr2", 32'(wr_addr[base + 2]), 32'd2);
      check("b2b_data0", 32'(wr_data[base]),     32'h0001);
      check("b2b_data1", 32'(wr_data[base + 1]), 32'h7FFF);
      check("b2b_data2", 32'(wr_data[base + 2]), 32'h8000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
